dmem_responder: RTL and testbench

- Data-memory responder at the far end of the memory stage's load/store port.
- Accepts one load or store request at a time from the memory stage.
- Holds it for a programmable number of wait states to model miss latency, then returns a response.
- Its busy/stall indication is what the memory stage forwards as its stall and uses to clear reg_data_ready on outstanding loads.

---
 rtl/dmem_responder.sv | 106 ++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable wait states.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic c_we, c_uns;
  logic [1:0] c_size;
  logic [31:0] c_addr, c_wdata;
  logic [31:0] mem [DEPTH];
  logic accept, enter_resp, a_we, a_uns, err;
  logic [1:0] a_size, lane;
  logic [31:0] a_addr, a_wdata, word, wrep, ld;
  logic [3:0] be;
  logic [15:0] half;
  logic [7:0] byte_v;
  logic [AW-1:0] idx;
  assign accept = req_valid && req_ready;
  assign enter_resp = (state == WAIT && cnt == 4'd0) || (accept && LATENCY == 0);
  // In IDLE the live request is used so a zero-latency build can commit on the accepting edge
  assign a_we = (state == IDLE) ? req_we : c_we;
  assign a_uns = (state == IDLE) ? req_unsigned : c_uns;
  assign a_size = (state == IDLE) ? req_size : c_size;
  assign a_addr = (state == IDLE) ? req_addr : c_addr;
  assign a_wdata = (state == IDLE) ? req_wdata : c_wdata;
  assign lane = a_addr[1:0];
  assign idx = a_addr[AW+1:2];
  assign word = mem[idx];
  assign err = a_size == 2'd3 || (a_size == 2'd1 && a_addr[0]) ||
               (a_size == 2'd2 && a_addr[1:0] != 2'd0) || (|a_addr[31:AW+2]);
  assign be = a_size == 2'd0 ? 4'b0001 << lane : a_size == 2'd1 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wrep = a_size == 2'd0 ? {4{a_wdata[7:0]}} : a_size == 2'd1 ? {2{a_wdata[15:0]}} : a_wdata;
  assign byte_v = word[{lane, 3'b000} +: 8];
  assign half = a_addr[1] ? word[31:16] : word[15:0];
  assign ld = a_size == 2'd0 ? {{24{~a_uns & byte_v[7]}}, byte_v} :
              a_size == 2'd1 ? {{16{~a_uns & half[15]}}, half} : word;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? (LATENCY == 0 ? RESP : WAIT) : IDLE;
      WAIT: state_nx = cnt == 4'd0 ? RESP : WAIT;
      RESP: state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
      c_we <= 1'b0;
      c_uns <= 1'b0;
      c_size <= 2'd0;
      c_addr <= 32'd0;
      c_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
        c_we <= req_we;
        c_uns <= req_unsigned;
        c_size <= req_size;
        c_addr <= req_addr;
        c_wdata <= req_wdata;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err <= err;
        rsp_rdata <= (err || a_we) ? 32'd0 : ld;
      end
    end
  end
  // Array has no reset; it is touched only on the RESP entry edge
  always_ff @(posedge clk) begin
    if (enter_resp && a_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table, randomized model comparison and corner sequences for dmem_responder.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 0, req_we = 0, req_unsigned = 0, rsp_ready = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic b_req_valid = 0, b_req_we = 0, b_req_unsigned = 0, b_rsp_ready = 1;
  logic [1:0] b_req_size = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [31:0] b_rsp_rdata;
  int checks = 0;
  int errors = 0;
  logic [7:0] bmem [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  typedef struct {
    logic we;
    logic [1:0] size;
    logic uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic err;
  } vec_t;
  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-addressed little-endian memory model
  task automatic model(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int n;
    longint v;
    n = 1 << size;
    err = size == 2'd3 || (addr % n) != 0 || addr >= 4 * DEPTH;
    rd = 32'd0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < n; k++) bmem[int'(addr) + k] = wdata[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(bmem[int'(addr) + k]) << (8 * k));
        if (!uns && v[8*n-1]) v = v - (64'sd1 <<< (8 * n));
        rd = v[31:0];
      end
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold, input logic [31:0] exp_rd,
                     input logic exp_err, input string tag);
    int lat;
    logic bz, stable;
    logic [31:0] rd0;
    logic e0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    bz = 1'b1;
    while (!rsp_valid && lat < 40) begin
      bz = bz & busy & ~req_ready;
      @(posedge clk); #1;
      lat++;
    end
    bz = bz & busy & ~req_ready;
    chk($sformatf("%s latency", tag), 32'(lat), 32'(LAT + 1));
    chk($sformatf("%s busy", tag), 32'(bz), 32'd1);
    rd0 = rsp_rdata;
    e0 = rsp_err;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      stable = stable & rsp_valid & ~req_ready & (rsp_rdata === rd0) & (rsp_err === e0);
    end
    req_valid = 1'b0;
    if (hold > 0) chk($sformatf("%s hold stable", tag), 32'(stable), 32'd1);
    chk($sformatf("%s rdata", tag), rsp_rdata, exp_rd);
    chk($sformatf("%s err", tag), 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk($sformatf("%s handoff", tag), {29'd0, rsp_valid, req_ready, busy}, 32'b010);
  endtask

  initial begin
    logic [31:0] rd;
    logic e, we, uns;
    logic [1:0] sz;
    logic [31:0] ad, wd;
    int ones, r;
    logic prev, alt;
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF80, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h00008000, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'h00000080, 1'b0};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 32'hFFFF8000, 1'b0};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h0, 32'h11223344, 32'h0, 1'b0};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b1};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h11223344, 1'b0};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1};
    tbl[13] = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h0, 1'b0};
    tbl[14] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hA5A51234, 32'h0, 1'b0};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0};
    tbl[16] = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1};
    tbl[17] = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h00000012, 1'b0};
    tbl[18] = '{1'b1, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1};
    tbl[19] = '{1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5A5A5, 32'h0, 1'b0};
    tbl[20] = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h00001234, 1'b0};
    tbl[21] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {27'd0, req_ready, rsp_valid, busy, rsp_err, b_req_ready}, 32'b10001);
    chk("reset rdata", rsp_rdata, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) begin
      model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, e);
      txn(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, (i == 15) ? 5 : 0,
          tbl[i].rd, tbl[i].err, $sformatf("vec%0d", i));
    end
    // Reset during WAIT drops the pending store
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midwait busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("midwait reset outputs", {28'd0, req_ready, rsp_valid, busy, rsp_err}, 32'b1000);
    chk("midwait reset rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, 32'hA5A5A5A5, 1'b0, "after reset load");
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      model(1'b1, 2'd2, 1'b0, 32'(w * 4), wd, rd, e);
      txn(1'b1, 2'd2, 1'b0, 32'(w * 4), wd, 0, rd, e, $sformatf("init%0d", w));
    end
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom);
      uns = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      r = $urandom_range(0, 9);
      ad = r == 0 ? 32'h1000 + 32'($urandom_range(0, 255)) : r == 1 ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad & ~((32'd1 << sz) - 32'd1);
      model(we, sz, uns, ad, wd, rd, e);
      txn(we, sz, uns, ad, wd, $urandom_range(0, 2), rd, e, $sformatf("rnd%0d", i));
    end
    // Zero-latency instance with rsp_ready tied high
    b_req_we = 1'b1; b_req_size = 2'd2; b_req_addr = 32'h8; b_req_wdata = 32'h55AA55AA;
    b_req_valid = 1'b1;
    chk("l0 idle ready", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    chk("l0 store rsp_valid", {30'd0, b_rsp_valid, b_rsp_err}, 32'b10);
    b_req_we = 1'b0;
    @(posedge clk); #1;
    chk("l0 handoff", {30'd0, b_req_ready, b_rsp_valid}, 32'b10);
    @(posedge clk); #1;
    chk("l0 load rsp_valid", 32'(b_rsp_valid), 32'd1);
    chk("l0 load rdata", b_rsp_rdata, 32'h55AA55AA);
    ones = 0;
    alt = 1'b1;
    prev = b_req_ready;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ones += int'(b_req_ready);
      alt = alt & (b_req_ready != prev);
      prev = b_req_ready;
    end
    b_req_valid = 1'b0;
    chk("l0 b2b accepts", 32'(ones), 32'd5);
    chk("l0 b2b alternate", 32'(alt), 32'd1);
    @(posedge clk); #1;
    chk("l0 final idle", {30'd0, b_req_ready, b_busy}, 32'b10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
